// File: rtl/lcd_ctrl.sv
// lcd_ctrl: HD44780-style character LCD write engine.
// Runs the power-on init sequence (0x38, 0x0C, 0x01, 0x06) by itself. After
// that it accepts one command/data byte per handshake and drives EN/RS/DATA
// with setup, enable-pulse, hold and execution timing. The bus is write-only.
//
// Write handshake: a byte is taken on a rising edge where o_wr_rdy=1 and
// i_wr_vld=1. o_wr_rdy is high only in IDLE. i_wr_vld seen while busy is
// ignored, not queued. Holding i_wr_vld high streams one byte per busy
// window + 1 cycle.
//
// All pin outputs are registered. They are computed from the next state, so
// they line up with the state they describe.
// During init, the INIT_LOAD cycle counts as the last cycle of the wait that
// precedes it. The LCD still sees the full power-on and execution delays
// before each new byte is driven. An init command therefore costs the same
// number of cycles as a normal write window.
module lcd_ctrl #(
  parameter int unsigned SETUP_CYC      = 2,
  parameter int unsigned EN_CYC         = 4,
  parameter int unsigned HOLD_CYC       = 2,
  parameter int unsigned EXEC_CYC       = 8,
  parameter int unsigned CLEAR_EXEC_CYC = 32,
  parameter int unsigned INIT_WAIT_CYC  = 16
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_wr_vld,
  input  logic       i_wr_rs,
  input  logic [7:0] i_wr_data,
  output logic       o_wr_rdy,
  output logic       o_init_done,
  output logic       o_lcd_on,
  output logic       o_lcd_en,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic [7:0] o_lcd_data,
  output logic [2:0] o_dbg_state
);

  localparam logic [2:0] INIT_WAIT = 3'd0;
  localparam logic [2:0] INIT_LOAD = 3'd1;
  localparam logic [2:0] SETUP     = 3'd2;
  localparam logic [2:0] EN_HI     = 3'd3;
  localparam logic [2:0] HOLD      = 3'd4;
  localparam logic [2:0] EXEC      = 3'd5;
  localparam logic [2:0] IDLE      = 3'd6;

  // Terminal counts: each phase counts from 0 up to its *_LAST value.
  localparam logic [19:0] SETUP_LAST = 20'(SETUP_CYC - 1);
  localparam logic [19:0] EN_LAST    = 20'(EN_CYC - 1);
  localparam logic [19:0] HOLD_LAST  = 20'(HOLD_CYC - 1);
  localparam logic [19:0] EXE_LAST   = 20'(EXEC_CYC - 1);
  localparam logic [19:0] CLR_LAST   = 20'(CLEAR_EXEC_CYC - 1);
  // The INIT_LOAD cycle completes the power-on wait.
  localparam logic [19:0] WAIT_LAST  = (INIT_WAIT_CYC >= 2) ? 20'(INIT_WAIT_CYC - 2) : 20'd0;

  logic [2:0]  state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic        init_done_q, done_d;
  logic        on_q, en_q, rs_q, rdy_q;
  logic [7:0]  data_q;
  logic        ld;
  logic        ld_rs;
  logic [7:0]  ld_data;
  logic [19:0] exec_base, exec_last;

  // Execution wait for the latched byte.
  // Clear/home commands take the long wait.
  // Inside init, the wait is one shorter when another init byte follows,
  // because INIT_LOAD supplies the final cycle.
  always_comb begin
    exec_base = (!rs_q && (data_q == 8'h01 || data_q == 8'h02)) ? CLR_LAST : EXE_LAST;
    exec_last = exec_base;
    if (!init_done_q && idx_q != 2'd3 && exec_base != 20'd0) begin
      exec_last = exec_base - 20'd1;
    end
  end

  // Next-state, counter, init index and byte-latch decisions.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 20'd1;
    idx_d   = idx_q;
    done_d  = init_done_q;
    ld      = 1'b0;
    ld_rs   = rs_q;
    ld_data = data_q;
    case (state_q)
      INIT_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = INIT_LOAD;
          cnt_d   = 20'd0;
        end
      end
      INIT_LOAD: begin
        ld    = 1'b1;
        ld_rs = 1'b0;
        case (idx_q)
          2'd0:    ld_data = 8'h38;
          2'd1:    ld_data = 8'h0C;
          2'd2:    ld_data = 8'h01;
          default: ld_data = 8'h06;
        endcase
        state_d = SETUP;
        cnt_d   = 20'd0;
      end
      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = EN_HI;
          cnt_d   = 20'd0;
        end
      end
      EN_HI: begin
        if (cnt_q == EN_LAST) begin
          state_d = HOLD;
          cnt_d   = 20'd0;
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = EXEC;
          cnt_d   = 20'd0;
        end
      end
      EXEC: begin
        if (cnt_q == exec_last) begin
          cnt_d = 20'd0;
          if (!init_done_q && idx_q != 2'd3) begin
            idx_d   = idx_q + 2'd1;
            state_d = INIT_LOAD;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      IDLE: begin
        cnt_d = 20'd0;
        if (i_wr_vld) begin
          ld      = 1'b1;
          ld_rs   = i_wr_rs;
          ld_data = i_wr_data;
          state_d = SETUP;
        end
      end
      default: begin
        state_d = INIT_WAIT;
        cnt_d   = 20'd0;
      end
    endcase
  end

  // State and registered outputs. Reset drops EN and every pin immediately.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= INIT_WAIT;
      cnt_q       <= 20'd0;
      idx_q       <= 2'd0;
      init_done_q <= 1'b0;
      on_q        <= 1'b0;
      en_q        <= 1'b0;
      rs_q        <= 1'b0;
      data_q      <= 8'h00;
      rdy_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      init_done_q <= done_d;
      on_q        <= 1'b1;
      en_q        <= (state_d == EN_HI);
      rdy_q       <= (state_d == IDLE);
      if (ld) begin
        rs_q   <= ld_rs;
        data_q <= ld_data;
      end
    end
  end

  assign o_wr_rdy    = rdy_q;
  assign o_init_done = init_done_q;
  assign o_lcd_on    = on_q;
  assign o_lcd_en    = en_q;
  assign o_lcd_rs    = rs_q;
  assign o_lcd_rw    = 1'b0;
  assign o_lcd_data  = data_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// tb_lcd_ctrl: scenario tasks for lcd_ctrl.
// A pin monitor collects every EN pulse into a queue. Each task compares the
// pins and timings it observes against values derived from the timing rules:
// window = setup + en + hold + exec, where exec is the clear/home wait only
// for commands 0x01/0x02.
module tb_lcd_ctrl;

  localparam int SETUP_CYC      = 2;
  localparam int EN_CYC         = 4;
  localparam int HOLD_CYC       = 2;
  localparam int EXEC_CYC       = 8;
  localparam int CLEAR_EXEC_CYC = 32;
  localparam int INIT_WAIT_CYC  = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_vld = 1'b0;
  logic       wr_rs = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       o_wr_rdy, o_init_done, o_lcd_on, o_lcd_en, o_lcd_rs, o_lcd_rw;
  logic [7:0] o_lcd_data;
  logic [2:0] dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc;
  int rw_bad = 0;
  int stab_bad = 0;

  logic [7:0] init_seq [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};
  logic [8:0] mon_q[$];
  int         rise_q[$];
  logic [8:0] exp_q[$];

  lcd_ctrl #(
    .SETUP_CYC(SETUP_CYC), .EN_CYC(EN_CYC), .HOLD_CYC(HOLD_CYC),
    .EXEC_CYC(EXEC_CYC), .CLEAR_EXEC_CYC(CLEAR_EXEC_CYC), .INIT_WAIT_CYC(INIT_WAIT_CYC)
  ) dut (
    .i_clk(clk), .i_reset(rst_n), .i_wr_vld(wr_vld), .i_wr_rs(wr_rs),
    .i_wr_data(wr_data), .o_wr_rdy(o_wr_rdy), .o_init_done(o_init_done),
    .o_lcd_on(o_lcd_on), .o_lcd_en(o_lcd_en), .o_lcd_rs(o_lcd_rs),
    .o_lcd_rw(o_lcd_rw), .o_lcd_data(o_lcd_data), .o_dbg_state(dbg_state)
  );

  // Clock and cycle count since reset release.
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Pin monitor: records EN pulses and flags RW or bus changes while EN is high.
  logic       en_prev = 1'b0;
  logic [8:0] held = 9'h0;
  always @(negedge clk) begin
    if (!rst_n) begin
      en_prev = 1'b0;
    end else begin
      if (o_lcd_rw !== 1'b0) rw_bad++;
      if (o_lcd_en && !en_prev) begin
        mon_q.push_back({o_lcd_rs, o_lcd_data});
        rise_q.push_back(cyc);
        held = {o_lcd_rs, o_lcd_data};
      end else if (o_lcd_en && en_prev && ({o_lcd_rs, o_lcd_data} !== held)) begin
        stab_bad++;
      end
      en_prev = o_lcd_en;
    end
  end

  // Reference model: busy window for one byte.
  function automatic int exp_window(input logic rs, input logic [7:0] d);
    int ex;
    ex = (!rs && (d == 8'h01 || d == 8'h02)) ? CLEAR_EXEC_CYC : EXEC_CYC;
    return SETUP_CYC + EN_CYC + HOLD_CYC + ex;
  endfunction

  // Driver: one write, returning what the pins did.
  task automatic do_write(input logic rs, input logic [7:0] d, output int t_acc,
                          output int rise, output int width, output int rdy_cyc,
                          output logic [8:0] seen, output logic rdy_after, output logic ok);
    ok = 1'b1;
    for (int i = 0; i < 200 && o_wr_rdy !== 1'b1; i++) @(negedge clk);
    if (o_wr_rdy !== 1'b1) ok = 1'b0;
    wr_rs = rs; wr_data = d; wr_vld = 1'b1;
    @(negedge clk);
    t_acc = cyc; wr_vld = 1'b0;
    seen = {o_lcd_rs, o_lcd_data};
    rdy_after = o_wr_rdy;
    rise = -1; width = -1; rdy_cyc = -1;
    for (int i = 0; i < 100 && rdy_cyc < 0; i++) begin
      @(negedge clk);
      if (o_lcd_en === 1'b1 && rise < 0) rise = cyc;
      if (o_lcd_en === 1'b0 && rise >= 0 && width < 0) width = cyc - rise;
      if (o_wr_rdy === 1'b1) rdy_cyc = cyc;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({o_lcd_on, o_lcd_en, o_lcd_rs, o_lcd_rw, o_lcd_data, o_wr_rdy, o_init_done, dbg_state} !== 17'h0) begin
      errors++;
      $display("FAIL reset_outputs: got on=%b en=%b rs=%b rw=%b data=%h rdy=%b done=%b st=%0d, want all 0",
               o_lcd_on, o_lcd_en, o_lcd_rs, o_lcd_rw, o_lcd_data, o_wr_rdy, o_init_done, dbg_state);
    end
    mon_q.delete(); rise_q.delete();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({o_lcd_on, o_wr_rdy, o_init_done} !== 3'b100) begin
      errors++;
      $display("FAIL reset_release: got on/rdy/done=%b%b%b, want 100", o_lcd_on, o_wr_rdy, o_init_done);
    end
  endtask

  task automatic test_init();
    int rdy_at = -1;
    int done_at = -1;
    int exp_ready;
    logic [8:0] got, exp;
    exp_ready = INIT_WAIT_CYC;
    for (int i = 0; i < 4; i++) begin
      exp_ready += exp_window(1'b0, init_seq[i]);
      exp_q.push_back({1'b0, init_seq[i]});
    end
    for (int i = 0; i < 400 && rdy_at < 0; i++) begin
      @(negedge clk);
      if (o_init_done === 1'b1 && done_at < 0) done_at = cyc;
      if (o_wr_rdy === 1'b1) rdy_at = cyc;
    end
    checks++;
    if (rdy_at != exp_ready) begin
      errors++;
      $display("FAIL init_rdy_cycle: got %0d, want %0d", rdy_at, exp_ready);
    end
    checks++;
    if (done_at != exp_ready) begin
      errors++;
      $display("FAIL init_done_cycle: got %0d, want %0d", done_at, exp_ready);
    end
    checks++;
    if (mon_q.size() != 4) begin
      errors++;
      $display("FAIL init_pulse_count: got %0d, want 4", mon_q.size());
    end
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      got = (mon_q.size() > 0) ? mon_q.pop_front() : 9'bx;
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL init_byte: got rs/data=%h, want %h", got, exp);
      end
    end
    mon_q.delete(); rise_q.delete();
  endtask

  task automatic test_data_write();
    int t, rise, width, rdy_c;
    logic [8:0] seen;
    logic rdy_after, ok;
    do_write(1'b1, 8'h41, t, rise, width, rdy_c, seen, rdy_after, ok);
    checks++;
    if (!ok || seen !== 9'h141 || rdy_after !== 1'b0) begin
      errors++;
      $display("FAIL data_latch: got ok=%b rs/data=%h rdy=%b, want ok=1 141 rdy=0", ok, seen, rdy_after);
    end
    checks++;
    if (rise - t != SETUP_CYC || width != EN_CYC) begin
      errors++;
      $display("FAIL data_en_pulse: got delay=%0d width=%0d, want %0d %0d", rise - t, width, SETUP_CYC, EN_CYC);
    end
    checks++;
    if (rdy_c - t != exp_window(1'b1, 8'h41)) begin
      errors++;
      $display("FAIL data_window: got %0d, want %0d", rdy_c - t, exp_window(1'b1, 8'h41));
    end
    mon_q.delete(); rise_q.delete();
  endtask

  task automatic test_clear_then_cmd();
    int t, rise, width, rdy_c;
    logic [8:0] seen;
    logic rdy_after, ok;
    logic [7:0] cmds [3] = '{8'h01, 8'h80, 8'h02};
    for (int i = 0; i < 3; i++) begin
      do_write(1'b0, cmds[i], t, rise, width, rdy_c, seen, rdy_after, ok);
      checks++;
      if (!ok || seen !== {1'b0, cmds[i]} || rdy_c - t != exp_window(1'b0, cmds[i])) begin
        errors++;
        $display("FAIL cmd_window: cmd=%h got ok=%b rs/data=%h window=%0d, want window %0d",
                 cmds[i], ok, seen, rdy_c - t, exp_window(1'b0, cmds[i]));
      end
    end
    mon_q.delete(); rise_q.delete();
  endtask

  task automatic test_data_01();
    int t, rise, width, rdy_c;
    logic [8:0] seen;
    logic rdy_after, ok;
    do_write(1'b1, 8'h01, t, rise, width, rdy_c, seen, rdy_after, ok);
    checks++;
    if (!ok || seen !== 9'h101 || rdy_c - t != SETUP_CYC + EN_CYC + HOLD_CYC + EXEC_CYC) begin
      errors++;
      $display("FAIL data01_window: got ok=%b rs/data=%h window=%0d, want 101 window %0d",
               ok, seen, rdy_c - t, SETUP_CYC + EN_CYC + HOLD_CYC + EXEC_CYC);
    end
    mon_q.delete(); rise_q.delete();
  endtask

  task automatic test_random();
    int t, rise, width, rdy_c;
    logic [8:0] seen, got, exp;
    logic rdy_after, ok, rs;
    logic [7:0] d;
    for (int i = 0; i < 8; i++) begin
      rs = 1'($urandom_range(0, 1));
      d = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 2)) : 8'($urandom_range(0, 255));
      exp_q.push_back({rs, d});
      do_write(rs, d, t, rise, width, rdy_c, seen, rdy_after, ok);
      checks++;
      if (!ok || seen !== {rs, d} || rdy_c - t != exp_window(rs, d) || rise - t != SETUP_CYC) begin
        errors++;
        $display("FAIL rand_write: sent %b/%h got ok=%b rs/data=%h window=%0d en_delay=%0d, want window %0d delay %0d",
                 rs, d, ok, seen, rdy_c - t, rise - t, exp_window(rs, d), SETUP_CYC);
      end
    end
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      got = (mon_q.size() > 0) ? mon_q.pop_front() : 9'bx;
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL rand_scoreboard: got pulse %h, want %h", got, exp);
      end
    end
    mon_q.delete(); rise_q.delete();
  endtask

  task automatic test_back_to_back();
    int acc1, acc2, spacing;
    logic [8:0] got0, got1;
    for (int i = 0; i < 200 && o_wr_rdy !== 1'b1; i++) @(negedge clk);
    mon_q.delete(); rise_q.delete();
    wr_rs = 1'b1; wr_data = 8'h48; wr_vld = 1'b1;
    @(negedge clk);
    acc1 = cyc;
    wr_data = 8'($urandom_range(0, 255));
    for (int i = 0; i < 100 && o_wr_rdy !== 1'b1; i++) begin
      @(negedge clk);
      wr_data = (o_wr_rdy === 1'b1) ? 8'h49 : 8'($urandom_range(0, 255));
    end
    @(negedge clk);
    acc2 = cyc;
    wr_vld = 1'b0;
    for (int i = 0; i < 100 && o_wr_rdy !== 1'b1; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    checks++;
    if (acc2 - acc1 != exp_window(1'b1, 8'h48) + 1) begin
      errors++;
      $display("FAIL b2b_accept_spacing: got %0d, want %0d", acc2 - acc1, exp_window(1'b1, 8'h48) + 1);
    end
    checks++;
    if (mon_q.size() != 2) begin
      errors++;
      $display("FAIL b2b_pulse_count: got %0d, want 2", mon_q.size());
    end else begin
      got0 = mon_q[0]; got1 = mon_q[1];
      spacing = rise_q[1] - rise_q[0];
      checks++;
      if (got0 !== 9'h148 || got1 !== 9'h149 || spacing != exp_window(1'b1, 8'h48) + 1) begin
        errors++;
        $display("FAIL b2b_pulses: got %h %h spacing %0d, want 148 149 spacing %0d",
                 got0, got1, spacing, exp_window(1'b1, 8'h48) + 1);
      end
    end
    mon_q.delete(); rise_q.delete();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 200 && o_wr_rdy !== 1'b1; i++) @(negedge clk);
    wr_rs = 1'b1; wr_data = 8'h55; wr_vld = 1'b1;
    @(negedge clk);
    wr_vld = 1'b0;
    for (int i = 0; i < 20 && o_lcd_en !== 1'b1; i++) @(negedge clk);
    checks++;
    if (o_lcd_en !== 1'b1 || o_init_done !== 1'b1) begin
      errors++;
      $display("FAIL midreset_pre: got en=%b done=%b, want 1 1", o_lcd_en, o_init_done);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({o_lcd_on, o_lcd_en, o_lcd_rs, o_lcd_data, o_wr_rdy, o_init_done} !== 13'h0) begin
      errors++;
      $display("FAIL midreset_clear: got on=%b en=%b rs=%b data=%h rdy=%b done=%b, want all 0",
               o_lcd_on, o_lcd_en, o_lcd_rs, o_lcd_data, o_wr_rdy, o_init_done);
    end
    @(negedge clk);
    mon_q.delete(); rise_q.delete();
    rst_n = 1'b1;
    test_init();
  endtask

  task automatic test_rw_and_stability();
    checks++;
    if (rw_bad != 0 || stab_bad != 0) begin
      errors++;
      $display("FAIL rw_and_bus_stable: got rw_bad=%0d stab_bad=%0d, want 0 0", rw_bad, stab_bad);
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_data_write();
    test_clear_then_cmd();
    test_data_01();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_data_write();
    test_rw_and_stability();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
